alu_result_buffer: RTL and testbench

- Sits directly downstream of the alu and captures each committed ALU result with its flags and destination register index.
- Buffers entries in a small FIFO with a valid/ready handshake toward the writeback/register-file stage, so the execute stage can keep issuing while writeback stalls.
- Also keeps overflow statistics: a sticky flag and a saturating counter.

---
 rtl/alu_result_buffer.sv | 108 ++++++++++
 tb/tb_alu_result_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Result FIFO between the ALU and writeback: captures result, flags and destination
// register, hands them downstream with valid/ready, and tracks overflow statistics.
module alu_result_buffer #(
    parameter int N     = 32,
    parameter int REG_W = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_result,
    input  logic                       in_overflow,
    input  logic                       in_zero,
    input  logic                       in_equal,
    input  logic [REG_W-1:0]           in_rd,
    input  logic                       in_wr_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_result,
    output logic [2:0]                 out_flags,
    output logic [REG_W-1:0]           out_rd,
    output logic                       out_wr_en,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       clear_stats,
    output logic                       sticky_overflow,
    output logic [CNT_W-1:0]           overflow_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]     r_result [DEPTH];
    logic [2:0]       r_flags  [DEPTH];
    logic [REG_W-1:0] r_rd     [DEPTH];
    logic             r_wr_en  [DEPTH];

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_sticky;
    logic [CNT_W-1:0] r_ovf_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_rd_zero;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_rd_zero = (in_rd == '0);

    // Storage needs no reset: everything leaving the block is gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_result[r_wptr] <= in_result;
            r_flags[r_wptr]  <= {in_overflow, in_zero, in_equal};
            r_rd[r_wptr]     <= in_rd;
            r_wr_en[r_wptr]  <= in_wr_en && !w_rd_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky  <= 1'b0;
            r_ovf_cnt <= '0;
        end else if (clear_stats) begin
            r_sticky  <= 1'b0;
            r_ovf_cnt <= '0;
        end else if (w_push && in_overflow) begin
            r_sticky <= 1'b1;
            if (r_ovf_cnt != '1) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
        end
    end

    assign out_result      = out_valid ? r_result[r_rptr] : '0;
    assign out_flags       = out_valid ? r_flags[r_rptr]  : '0;
    assign out_rd          = out_valid ? r_rd[r_rptr]     : '0;
    assign out_wr_en       = out_valid ? r_wr_en[r_rptr]  : 1'b0;
    assign count           = r_count;
    assign sticky_overflow = r_sticky;
    assign overflow_count  = r_ovf_cnt;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized and directed bench for alu_result_buffer against a queue-based model;
// a second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_alu_result_buffer;

    localparam int N     = 32;
    localparam int REG_W = 5;
    localparam int DEPTH = 4;

    typedef struct {
        logic [N-1:0]     result;
        logic [2:0]       flags;
        logic [REG_W-1:0] rd;
        logic             wr_en;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_overflow, in_zero, in_equal, in_wr_en;
    logic [N-1:0]     in_result;
    logic [REG_W-1:0] in_rd;
    logic             out_ready, clear_stats;

    logic             in_ready, out_valid, out_wr_en, sticky_overflow;
    logic [N-1:0]     out_result;
    logic [2:0]       out_flags;
    logic [REG_W-1:0] out_rd;
    logic [2:0]       count;
    logic [15:0]      overflow_count;

    logic             s_in_ready, s_out_valid, s_out_wr_en, s_sticky;
    logic [N-1:0]     s_out_result;
    logic [2:0]       s_out_flags;
    logic [REG_W-1:0] s_out_rd;
    logic [2:0]       s_count;
    logic [1:0]       s_overflow_count;

    alu_result_buffer #(.N(N), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_overflow(in_overflow), .in_zero(in_zero), .in_equal(in_equal),
        .in_rd(in_rd), .in_wr_en(in_wr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_rd(out_rd), .out_wr_en(out_wr_en),
        .count(count), .clear_stats(clear_stats),
        .sticky_overflow(sticky_overflow), .overflow_count(overflow_count)
    );

    alu_result_buffer #(.N(N), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_result(in_result),
        .in_overflow(in_overflow), .in_zero(in_zero), .in_equal(in_equal),
        .in_rd(in_rd), .in_wr_en(in_wr_en),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
        .out_flags(s_out_flags), .out_rd(s_out_rd), .out_wr_en(s_out_wr_en),
        .count(s_count), .clear_stats(clear_stats),
        .sticky_overflow(s_sticky), .overflow_count(s_overflow_count)
    );

    always #5 clk = ~clk;

    entry_t q[$];
    bit     m_sticky;
    int     m_ovf;
    int     m_ovf_sat;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sticky  = 0;
        m_ovf     = 0;
        m_ovf_sat = 0;
    endtask

    task automatic check_all();
        entry_t h;
        h = '{result: '0, flags: '0, rd: '0, wr_en: 1'b0};
        if (q.size() != 0) h = q[0];
        chk("count", count, q.size());
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("out_valid", out_valid, q.size() != 0);
        chk("out_result", out_result, h.result);
        chk("out_flags", out_flags, h.flags);
        chk("out_rd", out_rd, h.rd);
        chk("out_wr_en", out_wr_en, h.wr_en);
        chk("sticky", sticky_overflow, m_sticky);
        chk("ovf_count", overflow_count, m_ovf);
        chk("sat_ovf_count", s_overflow_count, m_ovf_sat);
        chk("sat_out_result", s_out_result, h.result);
    endtask

    // One clock: inputs already driven after a negedge; model advances at the posedge.
    task automatic step();
        bit     push, pop;
        entry_t e;
        push = in_valid && (q.size() < DEPTH);
        pop  = (q.size() != 0) && out_ready;
        e.result = in_result;
        e.flags  = {in_overflow, in_zero, in_equal};
        e.rd     = in_rd;
        e.wr_en  = in_wr_en && (in_rd != 0);
        @(posedge clk);
        if (pop) q.delete(0);
        if (push) q.push_back(e);
        if (clear_stats) begin
            m_sticky = 0; m_ovf = 0; m_ovf_sat = 0;
        end else if (push && in_overflow) begin
            m_sticky  = 1;
            m_ovf     = (m_ovf < 65535) ? m_ovf + 1 : m_ovf;
            m_ovf_sat = (m_ovf_sat < 3) ? m_ovf_sat + 1 : m_ovf_sat;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit v, input int res, input bit ovf, input int rd,
                         input bit wr, input bit ordy, input bit clr);
        in_valid    = v;
        in_result   = res;
        in_overflow = ovf;
        in_zero     = (res == 0);
        in_equal    = res[0];
        in_rd       = rd[REG_W-1:0];
        in_wr_en    = wr;
        out_ready   = ordy;
        clear_stats = clr;
        step();
    endtask

    initial begin
        bit stalled;
        rst_n = 1'b0;
        in_valid = 0; in_result = '0; in_overflow = 0; in_zero = 0; in_equal = 0;
        in_rd = '0; in_wr_en = 0; out_ready = 0; clear_stats = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", in_ready, 1);
        @(negedge clk);

        // Single entry, then held while out_ready stays low
        drive(1, 5, 0, 3, 1, 0, 0);
        chk("tp1_valid", out_valid, 1);
        chk("tp1_result", out_result, 32'h5);
        chk("tp1_rd", out_rd, 3);
        chk("tp1_wr_en", out_wr_en, 1);
        chk("tp1_count", count, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("tp1_hold", out_result, 32'h5);
        drive(0, 0, 0, 0, 0, 1, 0);

        // Fill to full, refuse a fifth, then drain in order
        for (int i = 1; i <= 4; i++) drive(1, i, 0, i, 1, 0, 0);
        chk("full_count", count, 4);
        chk("full_ready", in_ready, 0);
        drive(1, 5, 0, 5, 1, 0, 0);
        chk("full_no_push", count, 4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", out_result, i);
            drive(0, 0, 0, 0, 0, 1, 0);
        end
        chk("drained_valid", out_valid, 0);
        chk("drained_result", out_result, 0);

        // Streaming: pointers wrap twice
        for (int i = 0; i < 10; i++) begin
            drive(1, i, 0, 1, 1, 1, 0);
            chk("stream_count", count, 1);
            chk("stream_head", out_result, i);
        end
        drive(0, 0, 0, 0, 0, 1, 0);

        // Overflow stats, rd=0 suppression, clear priority
        drive(1, 7, 1, 2, 1, 0, 0);
        drive(1, 8, 1, 0, 1, 0, 0);
        drive(1, 9, 1, 4, 1, 0, 0);
        chk("ovf3_count", overflow_count, 3);
        chk("ovf3_sticky", sticky_overflow, 1);
        drive(1, 10, 1, 6, 1, 0, 1);
        chk("clr_count", overflow_count, 0);
        chk("clr_sticky", sticky_overflow, 0);
        chk("clr_enqueued", count, 4);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("x0_result", out_result, 8);
        chk("x0_wr_en", out_wr_en, 0);
        chk("x0_rd", out_rd, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) drive(1, 100 + i, 1, 1, 1, 1, 0);
        chk("sat_ovf", s_overflow_count, 3);
        chk("wide_ovf", overflow_count, 5);
        drive(0, 0, 0, 0, 0, 1, 1);

        // Randomized traffic; upstream holds in_* while stalled
        stalled = 0;
        for (int c = 0; c < 400; c++) begin
            if (!stalled) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                in_result   = $urandom;
                in_overflow = ($urandom_range(0, 3) == 0);
                in_zero     = $urandom_range(0, 1);
                in_equal    = $urandom_range(0, 1);
                in_rd       = ($urandom_range(0, 4) == 0) ? '0 : REG_W'($urandom);
                in_wr_en    = $urandom_range(0, 1);
            end
            out_ready   = ($urandom_range(0, 2) != 0);
            clear_stats = ($urandom_range(0, 31) == 0);
            stalled = in_valid && (q.size() >= DEPTH);
            step();
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 0);

        // Asynchronous reset with three entries buffered
        drive(1, 11, 1, 1, 1, 0, 0);
        drive(1, 12, 0, 2, 1, 0, 0);
        drive(1, 13, 0, 3, 1, 0, 0);
        chk("pre_rst_count", count, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow_count, 0);
        chk("rst_result", out_result, 0);
        model_reset();
        in_valid = 0;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", in_ready, 1);
        @(negedge clk);
        drive(1, 42, 0, 9, 1, 0, 0);
        chk("post_rst_count", count, 1);
        chk("post_rst_result", out_result, 42);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("post_rst_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
